// File: rtl/bram_pkg.sv
// Shared BRAM definitions: read-latency modes and requester identifiers.
package bram_pkg;

  // Read latency modes for a BRAM with an optional output register.
  localparam int LOW_LATENCY      = 1;
  localparam int HIGH_PERFORMANCE = 2;

  // Number of Wishbone requesters sharing one BRAM port.
  localparam int NREQ = 2;

  typedef logic [0:0] req_id_t;

endpackage

// File: rtl/wb_bram_arb_if.sv
// Two-requester Wishbone pipelined bus, packed per requester (slice i = requester i).
interface wb_bram_arb_if #(
  parameter int CFGAW = 32,
  parameter int CFGDW = 32
);
  logic [bram_pkg::NREQ-1:0]       s_cyc_i;
  logic [bram_pkg::NREQ-1:0]       s_stb_i;
  logic [bram_pkg::NREQ-1:0]       s_we_i;
  logic [bram_pkg::NREQ*CFGAW-1:0] s_addr_i;
  logic [bram_pkg::NREQ*CFGDW-1:0] s_data_i;
  logic [bram_pkg::NREQ-1:0]       s_ack_o;
  logic [bram_pkg::NREQ-1:0]       s_stall_o;
  logic [bram_pkg::NREQ*CFGDW-1:0] s_data_o;
  logic [bram_pkg::NREQ-1:0]       busy;

  modport slave (
    input  s_cyc_i, s_stb_i, s_we_i, s_addr_i, s_data_i,
    output s_ack_o, s_stall_o, s_data_o, busy
  );

  modport master (
    output s_cyc_i, s_stb_i, s_we_i, s_addr_i, s_data_i,
    input  s_ack_o, s_stall_o, s_data_o, busy
  );
endinterface

// File: rtl/wb_bram_arb_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
  import bram_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output req_id_t         gid,
  output logic            gany
);

  req_id_t ptr;

  // Grant the lone requester, or the pointer's requester when both ask.
  always_comb begin
    grant = '0;
    gid   = ptr;
    gany  = |req;
    if (&req) begin
      grant[ptr] = 1'b1;
      gid        = ptr;
    end else if (req[0]) begin
      grant = 2'b01;
      gid   = 1'b0;
    end else if (req[1]) begin
      grant = 2'b10;
      gid   = 1'b1;
    end
  end

  // Hand priority to the loser after every contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (&req) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/wb_bram_arb.sv
// Arbitrates two Wishbone pipelined requesters onto one BRAM port and
// routes read data / acks back using a tag pipeline matched to BRAM latency.
module wb_bram_arb
  import bram_pkg::*;
#(
  parameter int CFGAW       = 32,
  parameter int CFGDW       = 32,
  parameter int DW          = 18,
  parameter int DEPTH       = 1024,
  parameter int SIGN_EXTEND = 0,
  parameter int OREG        = HIGH_PERFORMANCE,
  localparam int BRAMAW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  wb_bram_arb_if.slave      wb,
  output logic              bram_en,
  output logic              bram_we,
  output logic [BRAMAW-1:0] bram_addr,
  output logic [DW-1:0]     bram_dout,
  input  logic [DW-1:0]     bram_din,
  output logic              bram_regce
);

  // Tag stage whose valid bit lines up with bram_din for the chosen latency.
  localparam int RSTG = (OREG == LOW_LATENCY) ? 0 : 1;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  req_id_t          gid;
  logic             gany;
  logic [1:0]       tag_v;
  req_id_t          tag_id [2];
  logic             ret_v;
  req_id_t          ret_id;
  logic [NREQ-1:0]  dec;
  logic [1:0]       cnt [NREQ];
  logic [CFGDW-1:0] rdata;

  assign req = wb.s_cyc_i & wb.s_stb_i;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .gid   (gid),
    .gany  (gany)
  );

  assign wb.s_stall_o = req & ~grant;
  assign bram_regce   = 1'b1;

  // Steer the granted requester's beat onto the BRAM port.
  always_comb begin
    bram_en   = gany;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_dout = '0;
    if (gany) begin
      bram_we   = wb.s_we_i[gid];
      bram_addr = gid ? wb.s_addr_i[CFGAW +: BRAMAW] : wb.s_addr_i[BRAMAW-1:0];
      bram_dout = gid ? wb.s_data_i[CFGDW +: DW]     : wb.s_data_i[DW-1:0];
    end
  end

  // Tag pipeline shifts every cycle so each beat retires exactly when its data lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v     <= '0;
      tag_id[0] <= '0;
      tag_id[1] <= '0;
    end else begin
      tag_v     <= {tag_v[0], gany};
      tag_id[0] <= gid;
      tag_id[1] <= tag_id[0];
    end
  end

  assign ret_v  = tag_v[RSTG];
  assign ret_id = tag_id[RSTG];

  // Ack the owner of the retiring tag unless it has abandoned the cycle.
  always_comb begin
    wb.s_ack_o = '0;
    dec        = '0;
    if (ret_v) begin
      wb.s_ack_o[ret_id] = wb.s_cyc_i[ret_id];
      dec[ret_id]        = 1'b1;
    end
  end

  // Outstanding-access counters; aborted beats still retire through dec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 2'd1;
        end else if (dec[i] && !grant[i]) begin
          cnt[i] <= cnt[i] - 2'd1;
        end
      end
    end
  end

  // Busy flags mirror the outstanding counters.
  always_comb begin
    wb.busy = '0;
    for (int i = 0; i < NREQ; i++) wb.busy[i] = (cnt[i] != 2'd0);
  end

  if (SIGN_EXTEND != 0 && DW < CFGDW) begin : g_sext
    assign rdata = {{(CFGDW-DW){bram_din[DW-1]}}, bram_din};
  end else if (DW < CFGDW) begin : g_zext
    assign rdata = {{(CFGDW-DW){1'b0}}, bram_din};
  end else begin : g_full
    assign rdata = bram_din;
  end

  assign wb.s_data_o = {NREQ{rdata}};

endmodule

// File: tb/tb_wb_bram_arb.sv
// Scoreboard bench: two DUT configurations (HIGH_PERFORMANCE/zero-extend and
// LOW_LATENCY/sign-extend) share one stimulus stream and one reference model.
module tb_wb_bram_arb;
  import bram_pkg::*;

  localparam int AW    = 32;
  localparam int CDW   = 32;
  localparam int DW    = 18;
  localparam int DEPTH = 64;
  localparam int BAW   = 6;

  typedef struct packed {
    int          issue;
    int          due;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncyc = 0;
  int   checks = 0;
  int   passes = 0;

  logic [1:0]  cyc = '0, stb = '0, we = '0;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];

  logic           en0, we0, regce0, en1, we1, regce1;
  logic [BAW-1:0] addr0, addr1;
  logic [DW-1:0]  dout0, dout1, din0, din1;
  logic [DW-1:0]  mem0 [DEPTH];
  logic [DW-1:0]  mem1 [DEPTH];
  logic [DW-1:0]  r0a, r1a, r0b;

  logic [DW-1:0] mirror [DEPTH];
  logic          mptr = 1'b0;
  exp_t          q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  wb_bram_arb_if #(.CFGAW(AW), .CFGDW(CDW)) wbi0 ();
  wb_bram_arb_if #(.CFGAW(AW), .CFGDW(CDW)) wbi1 ();

  assign wbi0.s_cyc_i  = cyc;
  assign wbi0.s_stb_i  = stb;
  assign wbi0.s_we_i   = we;
  assign wbi0.s_addr_i = {addr[1], addr[0]};
  assign wbi0.s_data_i = {wdat[1], wdat[0]};
  assign wbi1.s_cyc_i  = cyc;
  assign wbi1.s_stb_i  = stb;
  assign wbi1.s_we_i   = we;
  assign wbi1.s_addr_i = {addr[1], addr[0]};
  assign wbi1.s_data_i = {wdat[1], wdat[0]};

  wb_bram_arb #(.CFGAW(AW), .CFGDW(CDW), .DW(DW), .DEPTH(DEPTH),
                .SIGN_EXTEND(0), .OREG(HIGH_PERFORMANCE)) dut0 (
    .clk(clk), .rst(rst), .wb(wbi0),
    .bram_en(en0), .bram_we(we0), .bram_addr(addr0), .bram_dout(dout0),
    .bram_din(din0), .bram_regce(regce0));

  wb_bram_arb #(.CFGAW(AW), .CFGDW(CDW), .DW(DW), .DEPTH(DEPTH),
                .SIGN_EXTEND(1), .OREG(LOW_LATENCY)) dut1 (
    .clk(clk), .rst(rst), .wb(wbi1),
    .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_dout(dout1),
    .bram_din(din1), .bram_regce(regce1));

  // Read-first BRAM with output register (2-cycle) for dut0.
  always @(posedge clk) begin
    if (en0) begin
      r0a <= mem0[addr0];
      if (we0) mem0[addr0] <= dout0;
    end
    if (regce0) r1a <= r0a;
  end
  assign din0 = r1a;

  // Read-first BRAM without output register (1-cycle) for dut1.
  always @(posedge clk) begin
    if (en1) begin
      r0b <= mem1[addr1];
      if (we1) mem1[addr1] <= dout1;
    end
  end
  assign din1 = r0b;

  function automatic int lat(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] ext(int k, logic [DW-1:0] v);
    if (k == 1) return {{(32-DW){v[DW-1]}}, v};
    return {{(32-DW){1'b0}}, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
  endtask

  // Present one beat, update the reference model and check the combinational outputs.
  task automatic apply(input logic [1:0] c, input logic [1:0] s, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    logic [1:0] r, gnt;
    int g, ma;
    exp_t e;
    cyc = c; stb = s; we = w;
    addr[0] = a0; addr[1] = a1; wdat[0] = d0; wdat[1] = d1;
    r = c & s;
    gnt = 2'b00;
    g = 0;
    if (r == 2'b11) begin
      g = int'(mptr);
      mptr = ~mptr;
    end else if (r[0]) g = 0;
    else if (r[1]) g = 1;
    if (r != 2'b00) begin
      gnt[g] = 1'b1;
      ma = int'(addr[g] % DEPTH);
      for (int k = 0; k < 2; k++) begin
        e.issue = ncyc;
        e.due   = ncyc + lat(k);
        e.rd    = ~w[g];
        e.data  = ext(k, mirror[ma]);
        q[k*2+g].push_back(e);
      end
      if (w[g]) mirror[ma] = wdat[g][DW-1:0];
    end
    #1;
    chk("stall0", wbi0.s_stall_o, r & ~gnt);
    chk("stall1", wbi1.s_stall_o, r & ~gnt);
    chk("bram_en", {en1, en0}, {2{r != 2'b00}});
    chk("bram_regce", {regce1, regce0}, 2'b11);
    if (r != 2'b00) begin
      chk("bram_we", {we1, we0}, {2{w[g]}});
      chk("bram_addr", {addr1, addr0}, {2{BAW'(addr[g] % DEPTH)}});
      chk("bram_dout", {dout1, dout0}, {2{wdat[g][DW-1:0]}});
    end else begin
      chk("bram_we_idle", {we1, we0}, 2'b00);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    apply(c, s, w, a0, a1, d0, d1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b11, 2'b00, 2'b00, 0, 0, 0, 0);
  endtask

  // Monitor: pops expected beats when due and compares acks, data and busy.
  always @(negedge clk) begin
    logic [1:0]  ack_a [2];
    logic [1:0]  busy_a [2];
    logic [31:0] dat_a [2][2];
    ack_a[0] = wbi0.s_ack_o;  busy_a[0] = wbi0.busy;
    ack_a[1] = wbi1.s_ack_o;  busy_a[1] = wbi1.busy;
    dat_a[0][0] = wbi0.s_data_o[31:0];  dat_a[0][1] = wbi0.s_data_o[63:32];
    dat_a[1][0] = wbi1.s_data_o[31:0];  dat_a[1][1] = wbi1.s_data_o[63:32];
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          chk("ack_in_reset", ack_a[k][i], 1'b0);
          chk("busy_in_reset", busy_a[k][i], 1'b0);
        end else begin
          logic eb, ea;
          exp_t e;
          eb = 1'b0;
          ea = 1'b0;
          e  = '0;
          foreach (q[k*2+i][j]) if (q[k*2+i][j].issue < ncyc) eb = 1'b1;
          if (q[k*2+i].size() > 0 && q[k*2+i][0].due == ncyc) begin
            e  = q[k*2+i].pop_front();
            ea = cyc[i];
          end
          chk($sformatf("ack k%0d r%0d", k, i), ack_a[k][i], ea);
          chk($sformatf("busy k%0d r%0d", k, i), busy_a[k][i], eb);
          if (ea && ack_a[k][i] && e.rd)
            chk($sformatf("rdata k%0d r%0d", k, i), dat_a[k][i], e.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i] = '0; mem1[i] = '0; mirror[i] = '0;
    end
    addr[0] = '0; addr[1] = '0; wdat[0] = '0; wdat[1] = '0;
    #2;
    chk("reset_ack", {wbi1.s_ack_o, wbi0.s_ack_o}, 4'h0);
    chk("reset_busy", {wbi1.busy, wbi0.busy}, 4'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // write then read back on requester 0
    drive(2'b01, 2'b01, 2'b01, 32'd5, 0, 32'h1234, 0);
    drive(2'b01, 2'b01, 2'b00, 32'd5, 0, 0, 0);
    idle(4);

    // negative 18-bit value: sign-extended on dut1, zero-extended on dut0
    drive(2'b10, 2'b10, 2'b10, 0, 32'd9, 0, 32'h20000);
    drive(2'b10, 2'b10, 2'b00, 0, 32'd9, 0, 0);
    idle(4);

    // contention for 4 cycles starting with pointer at 0
    for (int i = 0; i < 4; i++) drive(2'b11, 2'b11, 2'b00, 32'd5, 32'd9, 0, 0);
    idle(4);

    // three back-to-back reads on requester 1
    for (int i = 0; i < 3; i++) drive(2'b11, 2'b10, 2'b00, 0, 32'd5 + i, 0, 0);
    idle(4);

    // requester 0 abandons its cycle right after issuing
    drive(2'b01, 2'b01, 2'b00, 32'd5, 0, 0, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    idle(3);

    // reset with two reads in flight
    drive(2'b11, 2'b01, 2'b00, 32'd5, 0, 0, 0);
    apply(2'b11, 2'b10, 2'b00, 0, 32'd9, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_ack_now", {wbi1.s_ack_o, wbi0.s_ack_o}, 4'h0);
    chk("rst_busy_now", {wbi1.busy, wbi0.busy}, 4'h0);
    for (int j = 0; j < 4; j++) q[j].delete();
    mptr = 1'b0;
    cyc = 2'b11; stb = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    drive(2'b11, 2'b11, 2'b00, 32'd5, 32'd9, 0, 0);
    idle(4);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [1:0] c, s, w;
      logic [31:0] a0, a1;
      c[0] = ($urandom_range(0, 15) != 0);
      c[1] = ($urandom_range(0, 15) != 0);
      s = 2'($urandom_range(0, 3));
      w = 2'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 3) << 20) | $urandom_range(0, 7);
      a1 = ($urandom_range(0, 3) << 20) | $urandom_range(0, 7);
      drive(c, s, w, a0, a1, $urandom, $urandom);
    end
    idle(5);
    for (int j = 0; j < 4; j++) chk($sformatf("drain q%0d", j), q[j].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_bram_arb.md
WB_BRAM_ARB -- requirements
Module: wb_bram_arb

Interface
REQ-001 SHALL have parameter CFGAW, default 32, Wishbone address width.
REQ-002 SHALL have parameter CFGDW, default 32, Wishbone data width.
REQ-003 SHALL have parameter DW, default 18, BRAM data width (DW <= CFGDW).
REQ-004 SHALL have parameter DEPTH, default 1024, BRAM words; BRAMAW = clog2(DEPTH) localparam.
REQ-005 SHALL have parameter SIGN_EXTEND, default 0, nonzero replicates bram_din[DW-1] into upper read bits.
REQ-006 SHALL have parameter OREG, default HIGH_PERFORMANCE, read latency mode (LOW_LATENCY = 1 cycle, HIGH_PERFORMANCE = 2 cycles).
REQ-007 SHALL have ports: clk in 1 clock; rst in 1, asynchronous active-high reset.
REQ-008 s_cyc_i in 2; s_stb_i in 2; s_we_i in 2: per-requester Wishbone pipelined controls, bit i = requester i.
REQ-009 s_addr_i in 2*CFGAW; s_data_i in 2*CFGDW: packed per-requester address/write data, slice i = requester i.
REQ-010 s_ack_o out 2; s_stall_o out 2; s_data_o out 2*CFGDW: per-requester response.
REQ-011 bram_en out 1; bram_we out 1; bram_addr out BRAMAW; bram_dout out DW; bram_din in DW; bram_regce out 1.
REQ-012 busy out 2: requester i has ≥1 outstanding access.

Function
REQ-013 Request r_i = s_cyc_i[i] & s_stb_i[i]; at most one grant per cycle, combinational from r and priority pointer ptr.
REQ-014 Single request: granted, no stall. Both: requester ptr granted, other gets s_stall_o=1.
REQ-015 ptr SHALL toggle to the non-granted requester after any cycle where both requested; unchanged otherwise.
REQ-016 s_stall_o[i] = r_i & ~grant_i; non-requesting port stall = 0.
REQ-017 Granted beat drives bram_en=1, bram_we=s_we_i[g], bram_addr=addr slice g [BRAMAW-1:0], bram_dout=data slice g [DW-1:0]; no grant -> bram_en=0, bram_we=0.
REQ-018 bram_regce SHALL be constant 1.
REQ-019 Tag pipeline {valid, id} depth 2 SHALL shift every cycle; stage 0 loads {grant_any, g}.
REQ-020 Ack returns at stage 0 (LOW_LATENCY) or stage 1 (HIGH_PERFORMANCE): s_ack_o[id]=valid & s_cyc_i[id]; other bit 0.
REQ-021 Requester dropping cyc SHALL have in-flight acks suppressed (abort); tag still drains, counters still decrement.
REQ-022 Both s_data_o slices SHALL carry {pad, bram_din}, pad per SIGN_EXTEND; meaningful only with ack.
REQ-023 Per-requester outstanding counter (2 bits): +1 on grant, -1 on tag retire, both same cycle = hold; busy[i] = count != 0.
REQ-024 Back-to-back grants to same requester SHALL be accepted every cycle; throughput one access per cycle total.
REQ-025 Acks per requester SHALL return in issue order.

Reset
REQ-026 rst SHALL asynchronously clear tag pipeline, counters, ptr=0; outputs s_ack_o=0, busy=0 immediately.
REQ-027 During rst, combinational outputs follow REQ-016/017 with ptr=0; reset mid-access drops all pending acks, none emitted after release.

Structure
REQ-028 LOW_LATENCY, HIGH_PERFORMANCE constants SHALL come from shared bram_pkg; requester-id type and NREQ=2 SHALL be added there.
REQ-029 One sub-module natural: rr_arb2 (two-input round-robin grant + ptr register); datapath muxing in top level.

Verification
REQ-030 HIGH_PERFORMANCE, req0 write addr 5 data 0x1234, then read addr 5 -> bram_we=1 same cycle, read ack on s_ack_o[0] 2 cycles after read beat, s_data_o[0]=0x00001234.
REQ-031 Both stb every cycle, 4 cycles, ptr=0 -> grants 0,1,0,1; stall pattern 0/1 alternates inverted; acks alternate ports.
REQ-032 SIGN_EXTEND=1, bram_din=0x20000 (DW=18) -> s_data_o slices = 0xFFFE0000.
REQ-033 LOW_LATENCY, req1 three back-to-back reads -> three acks on consecutive cycles starting 1 cycle later, busy[1] high through last ack cycle.
REQ-034 Req0 drops cyc one cycle after issue (HIGH_PERFORMANCE) -> no s_ack_o[0], busy[0] returns 0 two cycles after issue.
REQ-035 rst asserted with two reads in flight -> s_ack_o=0 immediately, no acks after release, next contention grants requester 0.
